// File: rtl/frame_receiver.sv
// -----------------------------------------------------------------------------
// frame_receiver
//
// Serial frame receiver. Each frame is recovered from the serial line and
// checked. A good frame's {source ID, data word} goes into a small
// first-word-fall-through FIFO, which is read through a valid/ready port.
//
// Frame on the line (idle high), in order:
//   start(0), ID_WIDTH id bits LSB first, WORD_SIZE data bits LSB first,
//   [even parity over id+data], stop(1)
//
// Optional feature macro:
//   FRAME_RECEIVER_PARITY_EN - the frame carries the even-parity bit and
//                              parity_error is live. When the macro is not
//                              defined there is no parity bit and
//                              parity_error is tied low.
//
// Ports:
//   clock, reset_n  - single rising-edge clock, async active-low reset
//   serial_in       - raw serial line (synchronised internally)
//   data_out        - data word at FIFO head (0 when empty)
//   source_out      - source ID at FIFO head (0 when empty)
//   data_valid      - FIFO not empty
//   data_ready      - consumer takes the head entry (pop on valid && ready)
//   fifo_full       - FIFO holds FIFO_DEPTH entries
//   frame_error     - 1-cycle pulse, bad stop bit
//   parity_error    - 1-cycle pulse, bad parity (stop bit good)
//   dropped_count   - good frames lost to a full FIFO, saturates at 255
//   state_dbg       - receive FSM state, for observation only
//
// Handshake: an entry transfers on every rising edge where data_valid and
// data_ready are both high. data_valid does not depend on data_ready, and
// the head entry stays stable while data_valid is high and data_ready is low.
// -----------------------------------------------------------------------------
module frame_receiver #(
  parameter int WORD_SIZE      = 4,
  parameter int ID_WIDTH       = 4,
  parameter int CLOCKS_PER_BIT = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 serial_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic [ID_WIDTH-1:0]  source_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 fifo_full,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic [7:0]           dropped_count,
  output logic [2:0]           state_dbg
);

  localparam int FW = ID_WIDTH + WORD_SIZE;
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = $clog2(FW + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] LAST_CNT = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FW - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  // ---------------- line synchroniser (resets to idle level) ----------------
  logic sync1_q, line_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      line_q  <= sync1_q;
    end
  end

  // ---------------- receive FSM ----------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [FW-1:0]   shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            push;
  logic            par_bad;
  logic            bit_tick;

`ifdef FRAME_RECEIVER_PARITY_EN
  logic par_bad_q, par_bad_d, par_err_q, par_err_d;
  assign par_bad      = par_bad_q;
  assign parity_error = par_err_q;
`else
  assign par_bad      = 1'b0;
  assign parity_error = 1'b0;
`endif

  assign bit_tick  = (cnt_q == LAST_CNT);
  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef FRAME_RECEIVER_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
`ifdef FRAME_RECEIVER_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!line_q) state_d = START;
      end
      START: begin
        // Half a bit in: a line back high means the low was a glitch.
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = line_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {line_q, shift_q[FW-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
`ifdef FRAME_RECEIVER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
`ifdef FRAME_RECEIVER_PARITY_EN
          par_bad_d = line_q ^ (^shift_q);
`endif
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (!line_q) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end else if (par_bad) begin
`ifdef FRAME_RECEIVER_PARITY_EN
            par_err_d = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (line_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef FRAME_RECEIVER_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
    end
  end
`endif

  assign frame_error = frame_err_q;

  // ---------------- output FIFO ----------------
  // Entry layout matches the shift register: ID in the low bits, word above.
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          pop, do_push;

  assign data_valid = (count_q != '0);
  assign fifo_full  = (count_q == DEPTH);
  assign pop        = data_valid && data_ready;
  // When full, a same-cycle pop frees the slot the push needs.
  assign do_push    = push && (!fifo_full || pop);

  assign source_out = data_valid ? mem[rd_ptr_q][ID_WIDTH-1:0] : '0;
  assign data_out   = data_valid ? mem[rd_ptr_q][FW-1:ID_WIDTH] : '0;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dropped_count <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !do_push) count_q <= count_q - 1'b1;
      if (push && !do_push && dropped_count != 8'hFF)
        dropped_count <= dropped_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
module tb_frame_receiver;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       serial_in;
  logic       data_ready;
  logic [3:0] data_out;
  logic [3:0] source_out;
  logic       data_valid;
  logic       fifo_full;
  logic       frame_error;
  logic       parity_error;
  logic [7:0] dropped_count;
  logic [2:0] state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  frame_receiver #(
    .WORD_SIZE(4), .ID_WIDTH(4), .CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in),
    .data_out(data_out), .source_out(source_out), .data_valid(data_valid),
    .data_ready(data_ready), .fifo_full(fifo_full),
    .frame_error(frame_error), .parity_error(parity_error),
    .dropped_count(dropped_count), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];   // {id, word} of frames that must come out, in order
  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;

  // Count error pulse cycles; a pulse longer than one cycle shows up as >1.
  always @(negedge clock) begin
    if (frame_error)  fe_cnt++;
    if (parity_error) pe_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [3:0] id, input logic [3:0] dat,
                            input bit bad_par, input bit bad_stop);
    logic [7:0] f;
    f = {dat, id};
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(f[i]);
`ifdef FRAME_RECEIVER_PARITY_EN
    send_bit((^f) ^ bad_par);
`else
    if (bad_par) idle(0);
`endif
    send_bit(!bad_stop);
    if (bad_stop) begin
      serial_in = 1'b0;
      idle(20);
    end
    serial_in = 1'b1;
    idle(6);
  endtask

  // Waits (bounded) for data_valid, captures the head, then pops it.
  task automatic pop_one(output bit got, output logic [7:0] head);
    got  = 1'b0;
    head = '0;
    for (int c = 0; c < 100; c++) begin
      if (data_valid) begin
        got  = 1'b1;
        head = {source_out, data_out};
        break;
      end
      @(negedge clock);
    end
    if (got) begin
      data_ready = 1'b1;
      @(negedge clock);
      data_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0; serial_in = 1'b1; data_ready = 1'b0;
    idle(3);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", data_valid); end
    n_cmp++; if ({source_out, data_out} !== 8'h00) begin n_bad++; $display("FAIL reset_head got %h exp 00", {source_out, data_out}); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b exp 0", fifo_full); end
    n_cmp++; if ({frame_error, parity_error} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b exp 00", {frame_error, parity_error}); end
    n_cmp++; if (dropped_count !== 8'd0) begin n_bad++; $display("FAIL reset_dropped got %0d exp 0", dropped_count); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    reset_n = 1'b1;
    idle(4);
  endtask

  task automatic test_good_frame;
    int fe0, pe0; bit got; logic [7:0] head, exp;
    fe0 = fe_cnt; pe0 = pe_cnt;
    exp_q.push_back({4'd3, 4'hA});
    send_frame(4'd3, 4'hA, 1'b0, 1'b0);
    n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL good_valid got %b exp 1", data_valid); end
    n_cmp++; if ({source_out, data_out} !== exp_q[0]) begin n_bad++; $display("FAIL good_head got %h exp %h", {source_out, data_out}, exp_q[0]); end
    n_cmp++; if ((fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin n_bad++; $display("FAIL good_flags got %0d exp 0", (fe_cnt - fe0) + (pe_cnt - pe0)); end
    pop_one(got, head);
    exp = exp_q.pop_front();
    n_cmp++; if (!got || head !== exp) begin n_bad++; $display("FAIL good_pop got %b/%h exp 1/%h", got, head, exp); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL good_after_pop got %b exp 0", data_valid); end
  endtask

`ifdef FRAME_RECEIVER_PARITY_EN
  task automatic test_parity_error;
    int fe0, pe0;
    fe0 = fe_cnt; pe0 = pe_cnt;
    send_frame(4'd3, 4'hA, 1'b1, 1'b0);
    n_cmp++; if (pe_cnt - pe0 !== 1) begin n_bad++; $display("FAIL parity_pulse got %0d exp 1", pe_cnt - pe0); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL parity_no_frame_err got %0d exp 0", fe_cnt - fe0); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL parity_no_push got %b exp 0", data_valid); end
  endtask
`endif

  task automatic test_framing_error;
    int fe0, pe0; bit got; logic [7:0] head, exp;
    fe0 = fe_cnt; pe0 = pe_cnt;
    send_frame(4'd2, 4'h6, 1'b0, 1'b1);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL frame_pulse got %0d exp 1", fe_cnt - fe0); end
    n_cmp++; if (pe_cnt - pe0 !== 0) begin n_bad++; $display("FAIL frame_no_parity_err got %0d exp 0", pe_cnt - pe0); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL frame_no_push got %b exp 0", data_valid); end
    exp_q.push_back({4'd1, 4'h5});
    send_frame(4'd1, 4'h5, 1'b0, 1'b0);
    pop_one(got, head);
    exp = exp_q.pop_front();
    n_cmp++; if (!got || head !== exp) begin n_bad++; $display("FAIL frame_recover got %b/%h exp 1/%h", got, head, exp); end
  endtask

  task automatic test_overflow;
    logic [3:0] dat;
    logic [7:0] exp;
    for (int id = 0; id < 5; id++) begin
      dat = 4'($urandom_range(0, 15));
      if (id < 4) exp_q.push_back({4'(id), dat});
      send_frame(4'(id), dat, 1'b0, 1'b0);
    end
    n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got %b exp 1", fifo_full); end
    n_cmp++; if (dropped_count !== 8'd1) begin n_bad++; $display("FAIL ovf_dropped got %0d exp 1", dropped_count); end
    for (int c = 0; c < 50; c++) begin
      if (exp_q.size() == 0) break;
      if (data_valid) begin
        exp = exp_q.pop_front();
        n_cmp++; if ({source_out, data_out} !== exp) begin n_bad++; $display("FAIL ovf_drain got %h exp %h", {source_out, data_out}, exp); end
      end
      data_ready = 1'b1;
      @(negedge clock);
    end
    data_ready = 1'b0;
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL ovf_drain_timeout got %0d left exp 0", exp_q.size()); end
    exp_q.delete();
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got %b exp 0", data_valid); end
  endtask

  task automatic test_glitch;
    int fe0, pe0;
    fe0 = fe_cnt; pe0 = pe_cnt;
    serial_in = 1'b0;
    @(negedge clock);
    serial_in = 1'b1;
    idle(12);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL glitch_no_push got %b exp 0", data_valid); end
    n_cmp++; if ((fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin n_bad++; $display("FAIL glitch_flags got %0d exp 0", (fe_cnt - fe0) + (pe_cnt - pe0)); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL glitch_state got %0d exp 0", state_dbg); end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] dat; bit got; logic [7:0] head, exp;
    // Leave one entry in the FIFO so the reset has something to clear.
    send_frame(4'd7, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b exp 0", data_valid); end
    n_cmp++; if ({source_out, data_out} !== 8'h00) begin n_bad++; $display("FAIL rst_mid_head got %h exp 00", {source_out, data_out}); end
    n_cmp++; if (dropped_count !== 8'd0) begin n_bad++; $display("FAIL rst_mid_dropped got %0d exp 0", dropped_count); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL rst_mid_state got %0d exp 0", state_dbg); end
    exp_q.delete();
    serial_in = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(3);
    dat = 4'($urandom_range(0, 15));
    exp_q.push_back({4'd9, dat});
    send_frame(4'd9, dat, 1'b0, 1'b0);
    pop_one(got, head);
    exp = exp_q.pop_front();
    n_cmp++; if (!got || head !== exp) begin n_bad++; $display("FAIL rst_mid_next_frame got %b/%h exp 1/%h", got, head, exp); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good_frame();
`ifdef FRAME_RECEIVER_PARITY_EN
    test_parity_error();
`endif
    test_framing_error();
    test_overflow();
    test_glitch();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
